logpix: RTL and testbench
=========================

LOGPIX -- requirements
Module: logpix

Interface
REQ-001 The block SHALL have parameter IW, default 16, giving the signed width of each FFT real/imag input; legal range 4..16.
REQ-002 The block SHALL have parameter OFFSET, default 0, a signed 9-bit value added to the log code before saturation.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 i_clk  in  1  clock, all logic on rising edge.
REQ-005 i_reset_n  in  1  asynchronous active-low reset.
REQ-006 i_valid  in  1  input bin valid.
REQ-007 o_ready  out  1  block accepts the input bin this cycle.
REQ-008 i_re, i_im  in  IW each  signed real and imaginary parts of the FFT bin.
REQ-009 i_last  in  1  final bin of the FFT frame.
REQ-010 o_valid  out  1  pixel valid.
REQ-011 i_ready  in  1  downstream colour-map stage accepts the pixel.
REQ-012 o_pixel  out  8  log-magnitude pixel index.
REQ-013 o_last  out  1  pixel is the final bin of the frame.

Function
REQ-014 An input SHALL transfer when i_valid && o_ready; an output SHALL transfer when o_valid && i_ready.
REQ-015 The pipeline SHALL have four register stages, each with its own valid bit:
- S1 registers re², im².
- S2 registers mag2 = re²+im² as an unsigned 2*IW-bit value, which never overflows.
- S3 registers the log code.
- S4 is the output register.
REQ-016 The pipeline SHALL advance as a whole when ce = !o_valid || i_ready, and SHALL hold every stage when ce=0; o_ready SHALL equal ce.
REQ-017 Latency SHALL be 4 cycles from input transfer to o_valid when i_ready is held high; throughput SHALL be one bin per cycle.
REQ-018 The log code SHALL be L = 8*e + m:
- e is the index of the most-significant set bit of mag2.
- m is the 3 bits immediately below that bit, zero-padded when e<3.
- mag2=0 SHALL give L=0.
REQ-019 The pixel SHALL be o_pixel = clamp(L + OFFSET, 0, 255), computed in signed 10-bit arithmetic.
REQ-020 i_last SHALL travel with its sample and appear on o_last with that sample's pixel.
REQ-021 No sample SHALL be dropped, duplicated or reordered under any i_valid/i_ready pattern; at most 4 samples are in flight.
REQ-022 While stalled, o_pixel and o_last SHALL be held stable.

Reset
REQ-023 Asserting i_reset_n low SHALL immediately clear all stage valid bits, o_valid, o_pixel (0x00), o_last (0) and the frame-start flag, which resets to 1.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight samples; no pre-reset sample SHALL appear after release.
REQ-025 Data registers other than the outputs need no reset.

Configuration
REQ-026 With macro LOGPIX_DCBLANK_EN defined, the block SHALL keep a frame-start flag. The flag:
- is set at reset;
- is cleared on any input transfer;
- is set again on an input transfer with i_last=1.
The sample accepted while the flag is 1 (bin 0, DC) SHALL produce o_pixel=0x00 regardless of value or OFFSET.
REQ-027 Without LOGPIX_DCBLANK_EN, the flag and blanking logic SHALL be absent and bin 0 SHALL be mapped like every other bin.

Structure
REQ-028 Package logpix_pkg SHALL hold the following constants and typedef:
- PIXEL_W=8;
- MANT_W=3;
- the pixel_t typedef;
- the OFFSET width constant (9).
REQ-029 A combinational sub-module msbidx SHALL return the MSB index and 3-bit mantissa of a 2*IW-bit word, plus a zero flag.

Verification
REQ-030 Basic mapping, OFFSET=0, i_ready=1:
- re=0, im=0 -> 0x00;
- re=16, im=0 -> 0x40;
- re=3, im=4 (mag2=25) -> 0x24;
- each appears exactly 4 cycles after acceptance.
REQ-031 Saturation:
- re=im=-32768, OFFSET=0 -> 0xF8;
- same input, OFFSET=+16 -> 0xFF;
- re=im=0, OFFSET=-128 -> 0x00.
REQ-032 Backpressure:
- i_ready=0 for 10 cycles while 6 bins are offered -> o_ready falls once 4 are held;
- after i_ready=1, all 6 pixels emerge in order with none lost or duplicated.
REQ-033 Framing: two 8-bin frames, i_last on bins 8 and 16 -> o_last only on outputs 8 and 16.
REQ-034 With LOGPIX_DCBLANK_EN and bin 0 set to re=16: outputs 1 and 9 SHALL be 0x00 while all others are correct; without the macro, output 1 SHALL be 0x40.
REQ-035 Reset with 3 samples in flight -> o_valid=0 and o_pixel=0 without waiting for a clock; after release, the next bin is the first output and is treated as frame start.

Source files
------------

// File: rtl/logpix_pkg.sv
// Shared widths, the pixel type and the signed clamp used by the logpix
// log-magnitude pixel mapper.
package logpix_pkg;

  localparam int PIXEL_W = 8;
  localparam int MANT_W  = 3;
  localparam int OFF_W   = 9;
  localparam int SUM_W   = 10;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Saturate a signed 10-bit sum into the 0..255 pixel range.
  function automatic pixel_t clampPixel(input logic signed [SUM_W-1:0] v);
    pixel_t p;
    if (v < $signed(10'd0)) begin
      p = '0;
    end else if (v > $signed(10'd255)) begin
      p = '1;
    end else begin
      p = v[PIXEL_W-1:0];
    end
    return p;
  endfunction

endpackage

// File: rtl/logpix_msbidx.sv
// Combinational leading-one detector: MSB index, the mantissa bits just
// below it (zero-padded for small indices) and an all-zero flag.
module msbidx
  import logpix_pkg::*;
#(
  parameter int W = 32,
  localparam int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]      word_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic [MANT_W-1:0] mant_o,
  output logic              zero_o
);

  // Shifting the word, padded with MANT_W zeros, right by the MSB index
  // leaves the bits under the leading one in the low positions.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < W; i++) begin
      if (word_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
    mant_o = MANT_W'({word_i, {MANT_W{1'b0}}} >> idx_o);
    zero_o = (word_i == '0);
  end

endmodule

// File: rtl/logpix.sv
// Four-stage FFT bin -> log-magnitude pixel mapper with valid/ready flow.
// Define LOGPIX_DCBLANK_EN to force the first bin of every frame to 0x00.
module logpix
  import logpix_pkg::*;
#(
  parameter int                      IW     = 16,
  parameter logic signed [OFF_W-1:0] OFFSET = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic signed [IW-1:0] i_re,
  input  logic signed [IW-1:0] i_im,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output pixel_t               o_pixel,
  output logic                 o_last
);

  localparam int MAG_W = 2 * IW;
  localparam int IDX_W = $clog2(MAG_W);

  logic                    ce;
  logic                    v1_q, v2_q, v3_q, oValid_q;
  logic                    last1_q, last2_q, last3_q, oLast_q;
  logic signed [MAG_W-1:0] reSq_d, imSq_d;
  logic        [MAG_W-1:0] reSq_q, imSq_q;
  logic        [MAG_W-1:0] mag2_d, mag2_q;
  logic [IDX_W-1:0]        msbIdx;
  logic [MANT_W-1:0]       mant;
  logic                    magZero;
  pixel_t                  lcode_d, lcode_q;
  logic signed [SUM_W-1:0] sum_d;
  pixel_t                  pixel_d, oPixel_q;

  // The whole pipe moves together whenever the output slot is free or drains.
  assign ce      = !oValid_q || i_ready;
  assign o_ready = ce;

  assign reSq_d = i_re * i_re;
  assign imSq_d = i_im * i_im;
  assign mag2_d = reSq_q + imSq_q;

  msbidx #(.W(MAG_W)) uMsb (
    .word_i (mag2_q),
    .idx_o  (msbIdx),
    .mant_o (mant),
    .zero_o (magZero)
  );

  assign lcode_d = magZero ? '0 : PIXEL_W'({msbIdx, mant});
  assign sum_d   = $signed({2'b00, lcode_q}) + $signed({OFFSET[OFF_W-1], OFFSET});

`ifdef LOGPIX_DCBLANK_EN
  logic frameStart_q;
  logic blank1_q, blank2_q, blank3_q;

  // The bin accepted right after reset or after a frame's last bin is DC.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frameStart_q <= 1'b1;
    end else if (i_valid && ce) begin
      frameStart_q <= i_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ce) begin
      blank1_q <= frameStart_q;
      blank2_q <= blank1_q;
      blank3_q <= blank2_q;
    end
  end

  assign pixel_d = blank3_q ? '0 : clampPixel(sum_d);
`else
  assign pixel_d = clampPixel(sum_d);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      oValid_q <= 1'b0;
      oPixel_q <= '0;
      oLast_q  <= 1'b0;
    end else if (ce) begin
      v1_q     <= i_valid;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      oValid_q <= v3_q;
      if (v3_q) begin
        oPixel_q <= pixel_d;
        oLast_q  <= last3_q;
      end
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge i_clk) begin
    if (ce) begin
      reSq_q  <= reSq_d;
      imSq_q  <= imSq_d;
      last1_q <= i_last;
      mag2_q  <= mag2_d;
      last2_q <= last1_q;
      lcode_q <= lcode_d;
      last3_q <= last2_q;
    end
  end

  assign o_valid = oValid_q;
  assign o_pixel = oPixel_q;
  assign o_last  = oLast_q;

endmodule

// File: tb/tb_logpix.sv
// Directed self-checking bench for logpix; three instances share stimulus
// and differ only in OFFSET (0, +16, -128).
module tb_logpix;
  import logpix_pkg::*;

  localparam int IW = 16;
`ifdef LOGPIX_DCBLANK_EN
  localparam bit DCB = 1'b1;
`else
  localparam bit DCB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, iValid, iLast, iReady;
  logic signed [IW-1:0] iRe, iIm;
  logic oReady0, oValid0, oLast0;
  logic oReady16, oValid16, oLast16;
  logic oReadyN, oValidN, oLastN;
  pixel_t oPixel0, oPixel16, oPixelN;

  logpix #(.IW(IW), .OFFSET(9'sd0)) dut0 (
    .i_clk(clk), .i_reset_n(rstN), .i_valid(iValid), .o_ready(oReady0),
    .i_re(iRe), .i_im(iIm), .i_last(iLast), .o_valid(oValid0),
    .i_ready(iReady), .o_pixel(oPixel0), .o_last(oLast0));

  logpix #(.IW(IW), .OFFSET(9'sd16)) dut16 (
    .i_clk(clk), .i_reset_n(rstN), .i_valid(iValid), .o_ready(oReady16),
    .i_re(iRe), .i_im(iIm), .i_last(iLast), .o_valid(oValid16),
    .i_ready(iReady), .o_pixel(oPixel16), .o_last(oLast16));

  logpix #(.IW(IW), .OFFSET(-9'sd128)) dutN (
    .i_clk(clk), .i_reset_n(rstN), .i_valid(iValid), .o_ready(oReadyN),
    .i_re(iRe), .i_im(iIm), .i_last(iLast), .o_valid(oValidN),
    .i_ready(iReady), .o_pixel(oPixelN), .o_last(oLastN));

  int nErr = 0;
  int nChk = 0;
  int stallLeft = 0;
  logic [7:0] expPix[$];
  logic       expLast[$];

  logic signed [IW-1:0] tRe  [8] = '{16'sd16, 16'sd3, 16'sd0, 16'sd1, 16'sd1, 16'sd2, -16'sd5, 16'sd100};
  logic signed [IW-1:0] tIm  [8] = '{16'sd0, 16'sd4, 16'sd0, 16'sd0, 16'sd1, 16'sd1, -16'sd12, 16'sd0};
  logic [7:0]           tPix [8] = '{8'h40, 8'h24, 8'h00, 8'h00, 8'h08, 8'h12, 8'h3A, 8'h69};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus with scoreboard bookkeeping for dut0.
  task automatic applyStimulus(input logic v, input logic signed [IW-1:0] re, input logic signed [IW-1:0] im,
                               input logic last, input logic [7:0] pix, output logic acc);
    @(negedge clk);
    iReady = (stallLeft == 0);
    if (stallLeft > 0) stallLeft--;
    iValid = v;
    iRe    = re;
    iIm    = im;
    iLast  = last;
    #1;
    if (oValid0 && !iReady && expPix.size() > 0) begin
      checkOutput("stallReady", 32'(oReady0), 32'd0);
      checkOutput("stallHeldCount", 32'(expPix.size()), 32'd4);
      checkOutput("stallPixel", 32'(oPixel0), 32'(expPix[0]));
      checkOutput("stallLast", 32'(oLast0), 32'(expLast[0]));
    end
    if (oValid0 && iReady) begin
      if (expPix.size() == 0) begin
        checkOutput("unexpectedOut", 32'(oValid0), 32'd0);
      end else begin
        checkOutput("pixel", 32'(oPixel0), 32'(expPix.pop_front()));
        checkOutput("last", 32'(oLast0), 32'(expLast.pop_front()));
      end
    end
    acc = v && oReady0;
    if (acc) begin
      expPix.push_back(pix);
      expLast.push_back(last);
    end
  endtask

  task automatic offer(input logic signed [IW-1:0] re, input logic signed [IW-1:0] im,
                       input logic last, input logic [7:0] pix);
    logic acc = 1'b0;
    for (int n = 0; n < 40 && !acc; n++) applyStimulus(1'b1, re, im, last, pix, acc);
    checkOutput("offerAccepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 40 && expPix.size() > 0; n++) applyStimulus(1'b0, '0, '0, 1'b0, 8'h00, acc);
    checkOutput("drainEmpty", 32'(expPix.size()), 32'd0);
  endtask

  // Frames of 8 bins from the table; two bin numbers may be DC-blanked.
  task automatic runFrames(input int nBins, input int blankA, input int blankB);
    for (int k = 1; k <= nBins; k++) begin
      logic [7:0] e;
      e = (DCB && (k == blankA || k == blankB)) ? 8'h00 : tPix[(k - 1) % 8];
      offer(tRe[(k - 1) % 8], tIm[(k - 1) % 8], (k % 8) == 0, e);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0; iValid = 1'b0; iRe = '0; iIm = '0; iLast = 1'b0; iReady = 1'b1;
    #12;
    checkOutput("rstValid", 32'(oValid0), 32'd0);
    checkOutput("rstPixel", 32'(oPixel0), 32'd0);
    checkOutput("rstLast", 32'(oLast0), 32'd0);
    checkOutput("rstReady", 32'(oReady0), 32'd1);
    @(negedge clk); rstN = 1'b1;

    $display("[TB] basic mapping and latency");
    @(negedge clk); iValid = 1'b1; iRe = 16'sd0; iIm = 16'sd0;
    @(negedge clk); iValid = 1'b0;
    @(negedge clk);
    @(negedge clk); checkOutput("latency3", 32'(oValid0), 32'd0);
    @(negedge clk); checkOutput("latency4", 32'(oValid0), 32'd1);
    checkOutput("zeroPixel", 32'(oPixel0), 32'h00);
    @(negedge clk); iValid = 1'b1; iRe = 16'sd16; iIm = 16'sd0;
    @(negedge clk); iRe = 16'sd3; iIm = 16'sd4;
    @(negedge clk); iValid = 1'b0;
    @(negedge clk);
    @(negedge clk); checkOutput("re16Valid", 32'(oValid0), 32'd1);
    checkOutput("re16Pixel", 32'(oPixel0), 32'h40);
    @(negedge clk); checkOutput("mag25Valid", 32'(oValid0), 32'd1);
    checkOutput("mag25Pixel", 32'(oPixel0), 32'h24);
    @(negedge clk); checkOutput("idleValid", 32'(oValid0), 32'd0);

    $display("[TB] saturation");
    @(negedge clk); iValid = 1'b1; iRe = 16'sh8000; iIm = 16'sh8000;
    @(negedge clk); iRe = 16'sd0; iIm = 16'sd0;
    @(negedge clk); iValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("satOff0", 32'(oPixel0), 32'hF8);
    checkOutput("satOff16", 32'(oPixel16), 32'hFF);
    checkOutput("satOffM128", 32'(oPixelN), 32'h78);
    @(negedge clk);
    checkOutput("zeroOff0", 32'(oPixel0), 32'h00);
    checkOutput("zeroOff16", 32'(oPixel16), 32'h10);
    checkOutput("zeroOffM128", 32'(oPixelN), 32'h00);
    checkOutput("zeroOffM128Valid", 32'(oValidN), 32'd1);

    $display("[TB] backpressure");
    stallLeft = 10;
    for (int i = 0; i < 6; i++) offer(tRe[i], tIm[i], 1'b0, tPix[i]);
    drain();

    $display("[TB] framing");
    runFrames(16, 9, 0);

    $display("[TB] reset with samples in flight");
    iReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); iValid = 1'b1; iRe = 16'sd100; iIm = 16'sd0; iLast = 1'b0;
    end
    @(negedge clk); iValid = 1'b0;
    #1;
    checkOutput("preResetValid", 32'(oValid0), 32'd1);
    checkOutput("preResetPixel", 32'(oPixel0), 32'h69);
    #2; rstN = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(oValid0), 32'd0);
    checkOutput("asyncRstPixel", 32'(oPixel0), 32'h00);
    checkOutput("asyncRstLast", 32'(oLast0), 32'd0);
    @(negedge clk);
    @(negedge clk); rstN = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk); #1;
      checkOutput("postResetIdle", 32'(oValid0), 32'd0);
    end
    runFrames(9, 1, 9);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
